// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Two-client (icache / dcache) cache-line burst arbiter in
//               front of a single-beat memory port. It arbitrates only when
//               idle, breaks ties round-robin, and runs one full
//               LINE_WORDS-beat burst per grant.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    // icache refill port
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic              ic_rvalid,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_done,

    // dcache refill / writeback port
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_gnt,
    output logic              dc_rvalid,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_wready,
    output logic              dc_done,

    // memory beat port
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,

    // status
    output logic              busy
);

    // Beat counter width; a one-bit floor keeps the vector legal for any size.
    localparam int c_BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    // Byte-offset bits inside one line (word index plus 2 byte bits).
    localparam int c_OFS_W  = c_BEAT_W + 2;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT  = c_BEAT_W'(LINE_WORDS - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_ONE   = c_BEAT_W'(1);
    localparam logic [ADDR_W-1:0]   c_ALIGN_MASK = {ADDR_W{1'b1}} << c_OFS_W;

    // FSM encoding; the XFER state also identifies the bus owner.
    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_IC_XFER = 2'd1;
    localparam logic [1:0] c_S_DC_XFER = 2'd2;

    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_base;
    logic                r_we;
    logic [c_BEAT_W-1:0] r_beat;
    logic                r_last_dc;     // 1 = dcache owned the last burst
    logic                r_gnt_first;   // high only in the first XFER cycle

    logic                w_idle;
    logic                w_busy;
    logic                w_ic_own;
    logic                w_dc_own;
    logic                w_arb;
    logic                w_pick_dc;
    logic [ADDR_W-1:0]   w_req_addr;
    logic                w_beat_hs;
    logic                w_last_hs;
    logic [ADDR_W-1:0]   w_beat_ofs;

    assign w_idle   = (r_state == c_S_IDLE);
    assign w_busy   = ~w_idle;
    assign w_ic_own = (r_state == c_S_IC_XFER);
    assign w_dc_own = (r_state == c_S_DC_XFER);

    // Arbitration: a lone requester wins; on a tie the client that did not
    // own the previous burst wins (r_last_dc resets to icache, so dcache
    // takes the first tie).
    assign w_arb      = w_idle & (ic_req | dc_req);
    assign w_pick_dc  = dc_req & (~ic_req | ~r_last_dc);
    assign w_req_addr = (w_pick_dc ? dc_addr : ic_addr) & c_ALIGN_MASK;

    // Every XFER cycle presents a beat, so a handshake is just mem_ready.
    assign w_beat_hs  = w_busy & mem_ready;
    assign w_last_hs  = w_beat_hs & (r_beat == c_LAST_BEAT);
    assign w_beat_ofs = ADDR_W'(r_beat) << 2;

    // Burst sequencer: arbitration in IDLE, beat counting and completion in XFER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_base      <= '0;
            r_we        <= 1'b0;
            r_beat      <= '0;
            r_last_dc   <= 1'b0;
            r_gnt_first <= 1'b0;
        end else begin
            r_gnt_first <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_arb) begin
                        r_state     <= w_pick_dc ? c_S_DC_XFER : c_S_IC_XFER;
                        r_base      <= w_req_addr;
                        r_we        <= w_pick_dc & dc_we;
                        r_beat      <= '0;
                        r_gnt_first <= 1'b1;
                    end
                end
                c_S_IC_XFER, c_S_DC_XFER: begin
                    // Requests and addresses are ignored here; the burst
                    // always runs to its last beat.
                    if (w_beat_hs) begin
                        r_beat <= r_beat + c_BEAT_ONE;
                        if (w_last_hs) begin
                            r_state   <= c_S_IDLE;
                            r_we      <= 1'b0;
                            r_last_dc <= w_dc_own;
                        end
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Grant pulses come straight from the first-cycle flag.
    assign ic_gnt    = r_gnt_first & w_ic_own;
    assign dc_gnt    = r_gnt_first & w_dc_own;

    // Memory request side; everything is zero outside a burst so that reset
    // (which forces IDLE) clears the port immediately.
    assign mem_valid = w_busy;
    assign mem_we    = w_busy & r_we;
    assign mem_addr  = w_busy ? (r_base + w_beat_ofs) : '0;
    assign mem_wdata = (w_dc_own & r_we) ? dc_wdata : '0;

    // Read return is combinational and steered only to the owner.
    assign ic_rvalid = w_ic_own & mem_ready;
    assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
    assign dc_rvalid = w_dc_own & ~r_we & mem_ready;
    assign dc_rdata  = dc_rvalid ? mem_rdata : '0;

    // Write-beat acceptance tells the dcache to advance to its next word.
    assign dc_wready = w_dc_own & r_we & mem_ready;

    // Completion fires with the final handshake, same cycle.
    assign ic_done   = w_ic_own & w_last_hs;
    assign dc_done   = w_dc_own & w_last_hs;

    assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Scoreboard bench for mem_bus_arbiter. Stimulus pushes the
//               expected grant and beat sequence; a negedge monitor pops and
//               compares whenever the DUT grants or completes a beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int LINE_WORDS = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;

    logic              clk;
    logic              rst_n;
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_gnt;
    logic              ic_rvalid;
    logic [DATA_W-1:0] ic_rdata;
    logic              ic_done;
    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_gnt;
    logic              dc_rvalid;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_wready;
    logic              dc_done;
    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    logic              stall_mode;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0;
    int cyc      = 0;
    int done_cyc = 0;
    int last_gap = 0;

    typedef struct {
        bit          is_gnt;
        bit          dc;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        bit          done;
    } exp_t;

    exp_t sb[$];

    // Memory model: read data is a fixed tag plus the low address half.
    assign mem_rdata = {16'hBEEF, mem_addr[15:0]};

    mem_bus_arbiter #(
        .LINE_WORDS (LINE_WORDS),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_gnt    (ic_gnt),
        .ic_rvalid (ic_rvalid),
        .ic_rdata  (ic_rdata),
        .ic_done   (ic_done),
        .dc_req    (dc_req),
        .dc_we     (dc_we),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_gnt    (dc_gnt),
        .dc_rvalid (dc_rvalid),
        .dc_rdata  (dc_rdata),
        .dc_wready (dc_wready),
        .dc_done   (dc_done),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Expected grant followed by LINE_WORDS beats from an aligned base.
    task automatic push_burst(input bit dc, input logic [31:0] base, input bit we,
                              input logic [31:0] wd0);
        exp_t e;
        e = '{is_gnt: 1'b1, dc: dc, addr: base, we: we, wdata: 32'h0, done: 1'b0};
        sb.push_back(e);
        for (int i = 0; i < LINE_WORDS; i++) begin
            e = '{is_gnt: 1'b0, dc: dc, addr: base + 32'(4 * i), we: we,
                  wdata: wd0 + 32'(i), done: (i == LINE_WORDS - 1)};
            sb.push_back(e);
        end
    endtask

    task automatic wait_gnt(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (ic_gnt || dc_gnt) seen = 1'b1;
        end
        if (!seen) fail_now({name, "_gnt_timeout"});
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            fail_now({name, "_drain_timeout"});
            sb.delete();
        end
    endtask

    // Monitor: compares every grant and every beat handshake against the scoreboard.
    logic              prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_wdata;
    logic              prev_we;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (busy) busy_cnt++;
        if (ic_done || dc_done) done_cyc = cyc;

        if (ic_gnt || dc_gnt) begin
            last_gap = cyc - done_cyc;
            if (sb.size() == 0) begin
                fail_now("unexpected_gnt");
            end else begin
                e = sb.pop_front();
                check("gnt_owner", {30'b0, ic_gnt, dc_gnt},
                      e.is_gnt ? (e.dc ? 32'd1 : 32'd2) : 32'd0);
            end
        end

        if (mem_valid && mem_ready) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_beat");
            end else begin
                e = sb.pop_front();
                if (e.is_gnt) begin
                    fail_now("missing_gnt");
                end else begin
                    check("beat_addr", mem_addr, e.addr);
                    check("beat_we", {31'b0, mem_we}, {31'b0, e.we});
                    check("beat_wdata", mem_wdata, e.we ? e.wdata : 32'h0);
                    check("beat_wready", {31'b0, dc_wready}, {31'b0, e.we});
                    check("beat_done", {30'b0, ic_done, dc_done},
                          e.done ? (e.dc ? 32'd1 : 32'd2) : 32'd0);
                    check("beat_rvalid", {30'b0, ic_rvalid, dc_rvalid},
                          e.we ? 32'd0 : (e.dc ? 32'd1 : 32'd2));
                    if (!e.we)
                        check("beat_rdata", e.dc ? dc_rdata : ic_rdata,
                              {16'hBEEF, e.addr[15:0]});
                end
            end
        end else begin
            check("no_beat_strobes", {27'b0, ic_done, dc_done, ic_rvalid, dc_rvalid, dc_wready}, 32'd0);
        end

        if (!(mem_valid && mem_we))
            check("wdata_zero", mem_wdata, 32'h0);

        if (prev_stall && mem_valid) begin
            check("stall_addr", mem_addr, prev_addr);
            check("stall_wdata", mem_wdata, prev_wdata);
            check("stall_we", {31'b0, mem_we}, {31'b0, prev_we});
        end
        prev_stall = mem_valid && !mem_ready;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        prev_we    = mem_we;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rst_n      = 1'b0;
        ic_req     = 1'b0;
        ic_addr    = '0;
        dc_req     = 1'b0;
        dc_we      = 1'b0;
        dc_addr    = '0;
        dc_wdata   = '0;
        mem_ready  = 1'b1;
        stall_mode = 1'b0;

        // Memory-ready pattern and dcache write-data stepping.
        fork
            begin : drv
                logic acc;
                forever begin
                    @(negedge clk);
                    acc = dc_wready;
                    @(posedge clk);
                    #1;
                    mem_ready = stall_mode ? ~mem_ready : 1'b1;
                    if (acc) dc_wdata = dc_wdata + 32'h1;
                end
            end
        join_none

        // Reset state
        #2;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_gnt", {30'b0, ic_gnt, dc_gnt}, 32'd0);
        check("rst_rvalid", {30'b0, ic_rvalid, dc_rvalid}, 32'd0);
        check("rst_rdata", ic_rdata | dc_rdata, 32'h0);
        check("rst_done_wready", {29'b0, ic_done, dc_done, dc_wready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Icache refill from 0x1008
        @(posedge clk); #1;
        b0 = busy_cnt;
        push_burst(1'b0, 32'h1000, 1'b0, 32'h0);
        ic_addr = 32'h1008;
        ic_req  = 1'b1;
        wait_gnt("t1");
        ic_req = 1'b0;
        wait_drain("t1");
        repeat (2) @(negedge clk);
        check("t1_busy_cycles", 32'(busy_cnt - b0), 32'd4);

        // Simultaneous requests after reset: dc, ic, dc
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        push_burst(1'b1, 32'h4010, 1'b0, 32'h0);
        push_burst(1'b0, 32'h3000, 1'b0, 32'h0);
        push_burst(1'b1, 32'h4010, 1'b0, 32'h0);
        dc_we   = 1'b0;
        dc_addr = 32'h401C;
        ic_addr = 32'h3004;
        ic_req  = 1'b1;
        dc_req  = 1'b1;
        wait_gnt("t2a");
        wait_gnt("t2b");
        @(posedge clk);
        check("t2_gap_after_done", 32'(last_gap), 32'd2);
        wait_gnt("t2c");
        ic_req = 1'b0;
        dc_req = 1'b0;
        wait_drain("t2");

        // Dcache writeback with mem_ready toggling
        @(posedge clk); #1;
        stall_mode = 1'b1;
        dc_wdata   = 32'hA0;
        dc_we      = 1'b1;
        dc_addr    = 32'h2000;
        dc_req     = 1'b1;
        push_burst(1'b1, 32'h2000, 1'b1, 32'hA0);
        wait_gnt("t3");
        dc_req = 1'b0;
        wait_drain("t3");
        stall_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("t3_idle_wdata", mem_wdata, 32'h0);
        check("t3_idle_busy", {31'b0, busy}, 32'd0);

        // Icache withdraws after grant; pending dcache follows
        @(posedge clk); #1;
        push_burst(1'b0, 32'h5000, 1'b0, 32'h0);
        push_burst(1'b1, 32'h6000, 1'b0, 32'h0);
        dc_we   = 1'b0;
        dc_addr = 32'h6008;
        ic_addr = 32'h5004;
        ic_req  = 1'b1;
        dc_req  = 1'b1;
        wait_gnt("t4a");
        ic_req = 1'b0;
        wait_gnt("t4b");
        @(posedge clk);
        check("t4_gap_after_done", 32'(last_gap), 32'd2);
        dc_req = 1'b0;
        wait_drain("t4");

        // Reset in the middle of an icache refill
        @(posedge clk); #1;
        push_burst(1'b0, 32'h7000, 1'b0, 32'h0);
        ic_addr = 32'h7000;
        ic_req  = 1'b1;
        wait_gnt("t5");
        ic_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_mem_addr", mem_addr, 32'h0);
        check("t5_beats_left", 32'(sb.size()), 32'd2);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_burst(1'b1, 32'h8000, 1'b0, 32'h0);
        dc_we   = 1'b0;
        dc_addr = 32'h8004;
        dc_req  = 1'b1;
        wait_gnt("t5b");
        dc_req = 1'b0;
        wait_drain("t5b");
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
